// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_out_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             br_q, br_d, bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbit, brn;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    dbit = a_q[0] ^ b_q[0] ^ br_q;
    brn  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          br_d    = borrow_in_i;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        diff_d = {dbit, diff_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = brn;
        // Counter parks at the last bit index rather than wrapping.
        if (cnt_q == LAST) begin
          bout_d  = brn;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign diff_o       = diff_q;
  assign borrow_out_o = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 directed ops and WIDTH=3 exhaustive back-to-back.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start3, bin3, busy3, done3, bout3;
  logic [2:0] a3, b3, diff3;

  int nvec = 0;
  int nerr = 0;
  logic [8:0] q8[$];
  logic [3:0] q3[$];

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .a_i(a8), .b_i(b8),
    .borrow_in_i(bin8), .busy_o(busy8), .done_o(done8), .diff_o(diff8),
    .borrow_out_o(bout8));

  serial_subtractor #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start_i(start3), .a_i(a3), .b_i(b3),
    .borrow_in_i(bin3), .busy_o(busy3), .done_o(done3), .diff_o(diff3),
    .borrow_out_o(bout3));

  task automatic test_reset();
    nvec++; if (busy8 !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy8); end
    nvec++; if (done8 !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", done8); end
    nvec++; if (diff8 !== 8'h00) begin nerr++; $display("FAIL reset_diff got %h want 00", diff8); end
    nvec++; if (bout8 !== 1'b0) begin nerr++; $display("FAIL reset_bout got %b want 0", bout8); end
    nvec++; if ({busy3, done3, bout3, diff3} !== 6'b0) begin
      nerr++; $display("FAIL reset_w3 got %b want 000000", {busy3, done3, bout3, diff3});
    end
  endtask

  task automatic wait_done8(input string nm, output int cyc);
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 20) begin @(posedge clk); cyc++; #1; end
    if (done8 !== 1'b1) begin nerr++; $display("FAIL %s_timeout no done after %0d cycles", nm, cyc); end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin, input string nm);
    int cyc;
    logic [8:0] exp;
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    q8.push_back({1'b0, a} - {1'b0, b} - {8'h00, bin});
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    nvec++; if (busy8 !== 1'b1) begin nerr++; $display("FAIL %s_busy got %b want 1", nm, busy8); end
    wait_done8(nm, cyc);
    nvec++; if (cyc != 8) begin nerr++; $display("FAIL %s_latency got %0d want 8", nm, cyc); end
    exp = q8.pop_front();
    nvec++; if ({bout8, diff8} !== exp) begin
      nerr++; $display("FAIL %s_result got %b_%h want %b_%h", nm, bout8, diff8, exp[8], exp[7:0]);
    end
    @(posedge clk); #1;
    nvec++; if ({busy8, done8} !== 2'b00) begin
      nerr++; $display("FAIL %s_after_done busy/done got %b want 00", nm, {busy8, done8});
    end
    repeat (3) @(posedge clk); #1;
    nvec++; if ({bout8, diff8} !== exp) begin
      nerr++; $display("FAIL %s_hold got %b_%h want %b_%h", nm, bout8, diff8, exp[8], exp[7:0]);
    end
  endtask

  task automatic test_basic();
    do_op(8'h05, 8'h03, 1'b0, "sub_5_3");
    do_op(8'h03, 8'h05, 1'b0, "sub_3_5");
    do_op(8'h00, 8'h00, 1'b1, "sub_0_0_b1");
    do_op(8'hFF, 8'hFF, 1'b0, "sub_ff_ff");
    do_op(8'hA7, 8'h3C, 1'b1, "sub_a7_3c_b1");
  endtask

  task automatic test_busy_ignore();
    int cyc, pulses;
    logic [8:0] exp;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h07F);
    @(posedge clk); #1 start8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); start8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
    @(negedge clk); start8 = 1'b0;
    #1 wait_done8("busy_ignore", cyc);
    exp = q8.pop_front();
    nvec++; if ({bout8, diff8} !== exp) begin
      nerr++; $display("FAIL busy_ignore_result got %b_%h want %b_%h", bout8, diff8, exp[8], exp[7:0]);
    end
    pulses = 0;
    repeat (12) begin @(posedge clk); #1; if (done8 === 1'b1) pulses++; end
    nvec++; if (pulses != 0) begin nerr++; $display("FAIL busy_ignore_extra_done got %0d want 0", pulses); end
  endtask

  task automatic test_reset_midop();
    int pulses;
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    nvec++; if ({busy8, done8, bout8, diff8} !== 11'h000) begin
      nerr++; $display("FAIL midop_reset got busy=%b done=%b bout=%b diff=%h want all 0", busy8, done8, bout8, diff8);
    end
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin @(posedge clk); #1; if (done8 === 1'b1) pulses++; end
    nvec++; if (pulses != 0) begin nerr++; $display("FAIL midop_ghost_done got %0d want 0", pulses); end
    do_op(8'h10, 8'h20, 1'b1, "after_reset");
  endtask

  task automatic test_back_to_back_w3();
    fork
      begin : drv
        @(negedge clk);
        a3 = 3'd0; b3 = 3'd0; bin3 = 1'b0; start3 = 1'b1;
        q3.push_back(4'd0);
        @(posedge clk);
        for (int k = 1; k < 128; k++) begin
          #1;
          a3 = 3'(k >> 4); b3 = 3'(k >> 1); bin3 = k[0];
          q3.push_back(4'({1'b0, a3} - {1'b0, b3} - {3'b000, bin3}));
          repeat (5) @(posedge clk);
        end
        #1 start3 = 1'b0;
      end
      begin : chk
        int gap;
        logic [3:0] exp;
        for (int n = 0; n < 128; n++) begin
          gap = 0;
          do begin @(negedge clk); gap++; end while (done3 !== 1'b1 && gap < 40);
          if (done3 !== 1'b1) begin
            nerr++; $display("FAIL w3_timeout op %0d no done", n);
            break;
          end
          exp = q3.pop_front();
          nvec++; if ({bout3, diff3} !== exp) begin
            nerr++; $display("FAIL w3_result op %0d got %b want %b", n, {bout3, diff3}, exp);
          end
          if (n > 0) begin
            nvec++; if (gap != 5) begin nerr++; $display("FAIL w3_spacing op %0d got %0d want 5", n, gap); end
          end
        end
      end
    join
  endtask

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
    #2 test_reset();
    @(posedge clk); #1 test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_basic();
    test_busy_ignore();
    test_reset_midop();
    test_back_to_back_w3();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
